pc_gen_stage: RTL and testbench

Fetch-address generator at the head of the IF pipeline, directly upstream of the branch target buffer. Holds the architectural fetch PC and emits one 16-byte fetch block per accepted cycle: four lane addresses, a lane-enable mask and the delay-slot flag. It consumes the BTB's same-cycle prediction (`validTake`/`validDest`/`needDelaySlot`/`fifthVAddr`) and redirects from the back end, and sequences the MIPS branch delay slot that falls outside the current block.

---
 rtl/pc_gen_stage_pkg.sv | 30 +++
 rtl/pc_lane_expand.sv | 41 ++++
 rtl/pc_gen_stage.sv | 114 +++++++++++
 tb/tb_pc_gen_stage.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/pc_gen_stage_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pc_gen_stage_pkg
// Description : Shared constants and types for the fetch-address generator:
//               lane count, enable-mask patterns, FSM state encoding and the
//               default reset fetch address.
// Revision    : 1.0 - initial release
// ============================================================================
package pc_gen_stage_pkg;

  // Number of 32-bit instruction lanes in one 16-byte fetch block.
  localparam int INST_NUM = 4;

  // Enable patterns (bit [3-k] enables lane k).
  localparam logic [INST_NUM-1:0] FOUR_WORDS  = 4'b1111;
  localparam logic [INST_NUM-1:0] SINGLE_WORD = 4'b1000;

  // Default fetch address after reset (MIPS boot vector).
  localparam logic [31:0] RESET_PC_DEFAULT = 32'hBFC0_0000;

  // SEQ  : normal sequential / predicted fetch.
  // DSLOT: the next block is fetched only for the delay slot of a taken
  //        branch that ended the previous block.
  typedef enum logic [0:0] {
    SEQ   = 1'b0,
    DSLOT = 1'b1
  } pcg_state_e;

endpackage : pc_gen_stage_pkg
`default_nettype wire

// File: rtl/pc_lane_expand.sv
`default_nettype none
// ============================================================================
// Module      : pc_lane_expand
// Description : Combinational expansion of the fetch PC into four word-lane
//               addresses and the lane-enable mask.
//   pc_i      in  [31:2] fetch PC (byte offset bits are never used)
//   dslot_i   in  1      delay-slot-only fetch
//   valid_i   in  1      block is meaningful
//   vaddr_o   out 128    lane k at [32k+31:32k] = {pc[31:4], k, 2'b00}
//   enable_o  out 4      bit [3-k] enables lane k
// Revision    : 1.0 - initial release
// ============================================================================
module pc_lane_expand
  import pc_gen_stage_pkg::*;
(
  input  logic [31:2]           pc_i,
  input  logic                  dslot_i,
  input  logic                  valid_i,
  output logic [32*INST_NUM-1:0] vaddr_o,
  output logic [INST_NUM-1:0]   enable_o
);

  logic [INST_NUM-1:0] seq_mask;

  for (genvar k = 0; k < INST_NUM; k++) begin : g_lane
    assign vaddr_o[32*k +: 32] = {pc_i[31:4], 2'(k), 2'b00};
  end

  // Lanes before the entry word of the block are not fetched: shifting the
  // full mask right by the word offset clears the leading (low-lane) bits.
  assign seq_mask = FOUR_WORDS >> pc_i[3:2];

  always_comb begin
    enable_o = '0;
    if (valid_i) begin
      enable_o = dslot_i ? SINGLE_WORD : seq_mask;
    end
  end

endmodule : pc_lane_expand
`default_nettype wire

// File: rtl/pc_gen_stage.sv
`default_nettype none
// ============================================================================
// Module      : pc_gen_stage
// Description : Fetch-address generator at the head of the IF pipeline. Holds
//               the fetch PC, emits one 16-byte block per accepted cycle and
//               sequences the MIPS delay slot that falls into the next block.
//   clk                  in  1    clock, rising edge
//   rst                  in  1    asynchronous active-low reset
//   EXP_flush_i/dest_i   in  1/32 exception redirect (highest priority)
//   FU_flush_i/FlushDest in  1/32 mispredict redirect
//   IF_ready_i           in  1    downstream accepts the current block
//   BTB_*                in       same-cycle prediction for the current block
//   PCG_valid_o          out 1    block outputs meaningful
//   PCG_VAddr_p_o        out 128  four lane addresses
//   PCG_instEnable_o     out 4    lane enables (bit [3-k] = lane k)
//   PCG_needDelaySlot_o  out 1    delay-slot-only fetch
// Revision    : 1.0 - initial release
// ============================================================================
module pc_gen_stage
  import pc_gen_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    EXP_flush_i,
  input  logic [31:0]             EXP_dest_i,
  input  logic                    FU_flush_i,
  input  logic [31:0]             FU_flushDest_i,
  input  logic                    IF_ready_i,
  input  logic                    BTB_validTake_i,
  input  logic [31:0]             BTB_validDest_i,
  input  logic                    BTB_needDelaySlot_i,
  input  logic [31:0]             BTB_fifthVAddr_i,
  output logic                    PCG_valid_o,
  output logic [32*INST_NUM-1:0]  PCG_VAddr_p_o,
  output logic [INST_NUM-1:0]     PCG_instEnable_o,
  output logic                    PCG_needDelaySlot_o
);

  logic [31:0] pc_q, pc_d;
  logic [31:0] pend_target_q, pend_target_d;
  pcg_state_e  state_q, state_d;
  logic        valid_q, valid_d;
  logic        advance;

  // --------------------------------------------------------------------------
  // Next-state logic: redirects first (they never wait for IF_ready_i), then
  // the normal advance of an accepted block.
  // --------------------------------------------------------------------------
  assign advance = valid_q && IF_ready_i;

  always_comb begin
    pc_d          = pc_q;
    pend_target_d = pend_target_q;
    state_d       = state_q;
    valid_d       = 1'b1;

    if (EXP_flush_i) begin
      pc_d    = EXP_dest_i;
      state_d = SEQ;
    end else if (FU_flush_i) begin
      // Any pending delay-slot target is abandoned; pend_target is simply
      // never consumed because the state leaves DSLOT.
      pc_d    = FU_flushDest_i;
      state_d = SEQ;
    end else if (advance) begin
      if (state_q == DSLOT) begin
        pc_d    = pend_target_q;
        state_d = SEQ;
      end else if (BTB_validTake_i && BTB_needDelaySlot_i) begin
        // Fetch the following block for the delay slot first, remember the
        // branch target for the block after it.
        pc_d          = BTB_fifthVAddr_i;
        pend_target_d = BTB_validDest_i;
        state_d       = DSLOT;
      end else if (BTB_validTake_i) begin
        pc_d = BTB_validDest_i;
      end else begin
        pc_d = BTB_fifthVAddr_i;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc_q          <= RESET_PC;
      pend_target_q <= '0;
      state_q       <= SEQ;
      valid_q       <= 1'b0;
    end else begin
      pc_q          <= pc_d;
      pend_target_q <= pend_target_d;
      state_q       <= state_d;
      valid_q       <= valid_d;
    end
  end

  // --------------------------------------------------------------------------
  // Outputs depend only on registers.
  // --------------------------------------------------------------------------
  pc_lane_expand u_lane_expand (
    .pc_i     (pc_q[31:2]),
    .dslot_i  (state_q == DSLOT),
    .valid_i  (valid_q),
    .vaddr_o  (PCG_VAddr_p_o),
    .enable_o (PCG_instEnable_o)
  );

  assign PCG_valid_o         = valid_q;
  assign PCG_needDelaySlot_o = (state_q == DSLOT) && valid_q;

endmodule : pc_gen_stage
`default_nettype wire

// File: tb/tb_pc_gen_stage.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_pc_gen_stage
// Description : Self-checking bench for pc_gen_stage: directed vector table,
//               hand-written stall/reset sequences and a randomized run
//               against a behavioural reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pc_gen_stage;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         exp_flush = 1'b0;
  logic [31:0]  exp_dest  = '0;
  logic         fu_flush  = 1'b0;
  logic [31:0]  fu_dest   = '0;
  logic         if_ready  = 1'b0;
  logic         btb_take  = 1'b0;
  logic [31:0]  btb_dest  = '0;
  logic         btb_nds   = 1'b0;
  logic [31:0]  btb_fifth = '0;
  logic         pcg_valid;
  logic [127:0] pcg_vaddr;
  logic [3:0]   pcg_en;
  logic         pcg_nds;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  pc_gen_stage #(.RESET_PC(32'hBFC0_0000)) dut (
    .clk                 (clk),
    .rst                 (rst),
    .EXP_flush_i         (exp_flush),
    .EXP_dest_i          (exp_dest),
    .FU_flush_i          (fu_flush),
    .FU_flushDest_i      (fu_dest),
    .IF_ready_i          (if_ready),
    .BTB_validTake_i     (btb_take),
    .BTB_validDest_i     (btb_dest),
    .BTB_needDelaySlot_i (btb_nds),
    .BTB_fifthVAddr_i    (btb_fifth),
    .PCG_valid_o         (pcg_valid),
    .PCG_VAddr_p_o       (pcg_vaddr),
    .PCG_instEnable_o    (pcg_en),
    .PCG_needDelaySlot_o (pcg_nds)
  );

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Block of four word addresses starting at the 16-byte-aligned base of pc.
  function automatic logic [127:0] block_of(input logic [31:0] pc);
    logic [127:0] v;
    logic [31:0]  base;
    base = pc & 32'hFFFF_FFF0;
    for (int k = 0; k < 4; k++) v[32*k +: 32] = base + 32'(4*k);
    return v;
  endfunction

  // Checks all four outputs against an expected block description.
  task automatic chk_block(input string tag, input logic ev, input logic [31:0] epc,
                           input logic [3:0] emask, input logic ends);
    chk({tag, ".valid"}, 128'(pcg_valid), 128'(ev));
    chk({tag, ".vaddr"}, pcg_vaddr, block_of(epc));
    chk({tag, ".mask"},  128'(pcg_en), 128'(emask));
    chk({tag, ".nds"},   128'(pcg_nds), 128'(ends));
  endtask

  task automatic set_in(input logic ef, input logic [31:0] ed, input logic ff, input logic [31:0] fd,
                        input logic rdy, input logic tk, input logic [31:0] dst, input logic nd,
                        input logic [31:0] fif);
    exp_flush = ef; exp_dest = ed; fu_flush = ff; fu_dest = fd; if_ready = rdy;
    btb_take = tk; btb_dest = dst; btb_nds = nd; btb_fifth = fif;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic        ef;
    logic [31:0] ed;
    logic        ff;
    logic [31:0] fd;
    logic        rdy;
    logic        tk;
    logic [31:0] dst;
    logic        nd;
    logic [31:0] fif;
    logic [31:0] e_pc;
    logic [3:0]  e_mask;
    logic        e_nds;
  } vec_t;

  vec_t vecs[$];

  task automatic add_vec(input logic ef, input logic [31:0] ed, input logic ff, input logic [31:0] fd,
                         input logic rdy, input logic tk, input logic [31:0] dst, input logic nd,
                         input logic [31:0] fif, input logic [31:0] epc, input logic [3:0] em,
                         input logic en);
    vec_t v;
    v.ef = ef; v.ed = ed; v.ff = ff; v.fd = fd; v.rdy = rdy; v.tk = tk; v.dst = dst;
    v.nd = nd; v.fif = fif; v.e_pc = epc; v.e_mask = em; v.e_nds = en;
    vecs.push_back(v);
  endtask

  // ---------------- reference model ----------------
  logic [31:0] m_pc;
  logic [31:0] m_pend;
  logic        m_in_dslot;
  logic        m_valid;

  task automatic model_reset();
    m_pc = 32'hBFC0_0000; m_pend = '0; m_in_dslot = 1'b0; m_valid = 1'b0;
  endtask

  // Applies the current inputs as seen at the coming clock edge.
  task automatic model_step();
    if (exp_flush) begin
      m_pc = exp_dest; m_in_dslot = 1'b0;
    end else if (fu_flush) begin
      m_pc = fu_dest; m_in_dslot = 1'b0;
    end else if (m_valid && if_ready) begin
      if (m_in_dslot) begin
        m_pc = m_pend; m_in_dslot = 1'b0;
      end else if (btb_take && btb_nds) begin
        m_pend = btb_dest; m_pc = btb_fifth; m_in_dslot = 1'b1;
      end else if (btb_take) begin
        m_pc = btb_dest;
      end else begin
        m_pc = btb_fifth;
      end
    end
    m_valid = 1'b1;
  endtask

  function automatic logic [3:0] model_mask();
    logic [3:0] m;
    m = '0;
    if (!m_valid) return m;
    if (m_in_dslot) return 4'b1000;
    for (int k = 0; k < 4; k++) if (k >= int'(m_pc[3:2])) m[3-k] = 1'b1;
    return m;
  endfunction

  logic [127:0] snap_vaddr;

  initial begin
    // ---------------- reset state ----------------
    set_in(0, 0, 0, 0, 1, 0, 0, 0, 0);
    tick(); tick();
    chk_block("reset", 1'b0, 32'hBFC0_0000, 4'b0000, 1'b0);
    rst = 1'b1;
    set_in(0, 0, 0, 0, 1, 0, 0, 0, 32'hBFC0_0010);
    tick();
    chk_block("first", 1'b1, 32'hBFC0_0000, 4'b1111, 1'b0);

    // ---------------- table ----------------
    //       ef ed            ff fd            rdy tk dst           nd fif            e_pc          mask    nds
    add_vec(0, 0,            0, 0,            1,  0, 0,            0, 32'hBFC0_0010, 32'hBFC0_0010, 4'b1111, 0);
    add_vec(0, 0,            1, 32'h8000_0008, 1,  0, 0,            0, 32'h1111_1110, 32'h8000_0008, 4'b0011, 0);
    add_vec(0, 0,            0, 0,            1,  0, 0,            0, 32'h8000_0010, 32'h8000_0010, 4'b1111, 0);
    add_vec(0, 0,            0, 0,            1,  1, 32'h8000_4000, 1, 32'h8000_0020, 32'h8000_0020, 4'b1000, 1);
    add_vec(0, 0,            0, 0,            1,  1, 32'h1234_5670, 0, 32'h9999_0000, 32'h8000_4000, 4'b1111, 0);
    add_vec(0, 0,            0, 0,            1,  1, 32'h8000_0104, 0, 32'h8000_4010, 32'h8000_0104, 4'b0111, 0);
    add_vec(0, 0,            0, 0,            1,  1, 32'h8000_2000, 1, 32'h8000_0110, 32'h8000_0110, 4'b1000, 1);
    add_vec(0, 0,            1, 32'h8000_1234, 0,  0, 0,            0, 32'h5555_0000, 32'h8000_1234, 4'b0111, 0);
    add_vec(0, 0,            0, 0,            1,  0, 0,            0, 32'h8000_1240, 32'h8000_1240, 4'b1111, 0);
    add_vec(1, 32'h8000_018C, 1, 32'h8000_0300, 1,  0, 0,            0, 32'h8000_1250, 32'h8000_018C, 4'b0001, 0);
    add_vec(1, 32'hBFC0_0380, 0, 0,            0,  0, 0,            0, 0,             32'hBFC0_0380, 4'b1111, 0);
    add_vec(1, 32'hFFFF_FFF0, 0, 0,            1,  0, 0,            0, 0,             32'hFFFF_FFF0, 4'b1111, 0);
    add_vec(0, 0,            0, 0,            1,  0, 0,            0, 32'h0000_0000, 32'h0000_0000, 4'b1111, 0);

    foreach (vecs[i]) begin
      set_in(vecs[i].ef, vecs[i].ed, vecs[i].ff, vecs[i].fd, vecs[i].rdy,
             vecs[i].tk, vecs[i].dst, vecs[i].nd, vecs[i].fif);
      tick();
      chk_block($sformatf("vec%0d", i), 1'b1, vecs[i].e_pc, vecs[i].e_mask, vecs[i].e_nds);
    end

    // ---------------- stall in DSLOT for 3 cycles ----------------
    set_in(0, 0, 0, 0, 1, 1, 32'h8000_6000, 1, 32'h0000_0010);
    tick();
    chk_block("dslot_enter", 1'b1, 32'h0000_0010, 4'b1000, 1'b1);
    snap_vaddr = block_of(32'h0000_0010);
    for (int c = 0; c < 3; c++) begin
      set_in(0, 0, 0, 0, 0, 1'($urandom), $urandom, 1'($urandom), $urandom);
      tick();
      chk_block($sformatf("stall%0d", c), 1'b1, 32'h0000_0010, 4'b1000, 1'b1);
      chk($sformatf("stall%0d.hold", c), pcg_vaddr, snap_vaddr);
    end
    set_in(0, 0, 0, 0, 1, 1, 32'hDEAD_BEE0, 1, 32'h4444_0000);
    tick();
    chk_block("dslot_exit", 1'b1, 32'h8000_6000, 4'b1111, 1'b0);

    // ---------------- asynchronous reset while in DSLOT ----------------
    set_in(0, 0, 0, 0, 1, 1, 32'h8000_7000, 1, 32'h8000_6010);
    tick();
    chk_block("dslot_again", 1'b1, 32'h8000_6010, 4'b1000, 1'b1);
    #2 rst = 1'b0;
    #1;
    chk_block("async_rst", 1'b0, 32'hBFC0_0000, 4'b0000, 1'b0);

    // ---------------- randomized run against the model ----------------
    tick(); tick();
    model_reset();
    rst = 1'b1;
    for (int c = 0; c < 400; c++) begin
      set_in(($urandom_range(15) == 0), $urandom, ($urandom_range(11) == 0), $urandom,
             ($urandom_range(3) != 0), 1'($urandom), $urandom, 1'($urandom), $urandom);
      model_step();
      tick();
      chk($sformatf("rnd%0d.valid", c), 128'(pcg_valid), 128'(m_valid));
      chk($sformatf("rnd%0d.vaddr", c), pcg_vaddr, block_of(m_pc));
      chk($sformatf("rnd%0d.mask", c), 128'(pcg_en), 128'(model_mask()));
      chk($sformatf("rnd%0d.nds", c), 128'(pcg_nds), 128'(m_in_dslot && m_valid));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_pc_gen_stage
`default_nettype wire
